io_port_mq: RTL and testbench

//  Multi-port front end for the multi-tree BMW PIFO SRAM core (LEVEL lanes, one per root).
//  - Accepts push/pop requests from NUM_PORTS clients using valid/ready handshakes.
//  - Routes each request to lane root = tree_id % LEVEL.
//  - Per lane: round-robin arbitration, request buffering, pop-tag tracking.
//  - Returns each pop result to the client that issued it. Core-full raises back-pressure, never a drop.

---
 rtl/io_port_mq.sv | 237 +++++++++++++++++++++++
 tb/tb_io_port_mq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_mq.sv
// io_port_mq
//   Multi-port request front end for a multi-lane (one lane per tree root)
//   PIFO core. Clients issue push/pop requests over valid/ready; each request
//   is steered to lane tree_id[LW-1:0], arbitrated round-robin among the
//   ports targeting that lane, buffered in a per-lane request FIFO and issued
//   to the core one command per lane per cycle. Every issued pop records its
//   requester in a per-lane tag FIFO so the core's result can be returned to
//   the right client. When several lanes return to one port in the same cycle
//   the lowest lane wins and the others park in a one-entry skid register.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_*             per-port request (valid, pop, tree id, push data)
//   o_req_ready         per-port accept (valid & ready = handshake)
//   o_rsp_valid/_data   per-port registered pop result
//   o_core_*            per-lane registered command to the core
//   i_core_full         per-lane core back-pressure
//   i_core_pop_*        per-lane pop result from the core
module io_port_mq #(
   parameter int PTW       = 16,
   parameter int MTW       = 0,
   parameter int LEVEL     = 4,
   parameter int TREE_NUM  = 4,
   parameter int NUM_PORTS = 2,
   parameter int REQ_DEPTH = 4,
   parameter int TAG_DEPTH = 8,
   localparam int DW  = MTW + PTW,
   localparam int TNB = $clog2(TREE_NUM),
   localparam int NP  = NUM_PORTS,
   localparam int PB  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NP-1:0]        i_req_valid,
   input  logic [NP-1:0]        i_req_pop,
   input  logic [NP*TNB-1:0]    i_req_tree_id,
   input  logic [NP*DW-1:0]     i_req_data,
   output logic [NP-1:0]        o_req_ready,
   output logic [NP-1:0]        o_rsp_valid,
   output logic [NP*DW-1:0]     o_rsp_data,
   output logic [LEVEL-1:0]     o_core_push,
   output logic [LEVEL-1:0]     o_core_pop,
   output logic [LEVEL*TNB-1:0] o_core_tree_id,
   output logic [LEVEL*DW-1:0]  o_core_data,
   input  logic [LEVEL-1:0]     i_core_full,
   input  logic [LEVEL-1:0]     i_core_pop_valid,
   input  logic [LEVEL*DW-1:0]  i_core_pop_data
);
   localparam int LW  = $clog2(LEVEL);
   localparam int RAW = $clog2(REQ_DEPTH);
   localparam int TAW = $clog2(TAG_DEPTH);
   // request entry: {pop, port, tree_id, data}
   localparam int EW  = 1 + PB + TNB + DW;

   logic [EW-1:0]    r_rq_mem  [LEVEL][REQ_DEPTH];
   logic [RAW-1:0]   r_rq_rd   [LEVEL];
   logic [RAW-1:0]   r_rq_wr   [LEVEL];
   logic [RAW:0]     r_rq_cnt  [LEVEL];
   logic [PB-1:0]    r_tag_mem [LEVEL][TAG_DEPTH];
   logic [TAW-1:0]   r_tag_rd  [LEVEL];
   logic [TAW-1:0]   r_tag_wr  [LEVEL];
   logic [TAW:0]     r_tag_cnt [LEVEL];
   logic [PB-1:0]    r_rr      [LEVEL];
   logic [LEVEL-1:0] r_skid_v;
   logic [PB-1:0]    r_skid_port [LEVEL];
   logic [DW-1:0]    r_skid_data [LEVEL];
   logic [LEVEL-1:0] r_core_push;
   logic [LEVEL-1:0] r_core_pop;
   logic [TNB-1:0]   r_core_tree [LEVEL];
   logic [DW-1:0]    r_core_data [LEVEL];
   logic [NP-1:0]    r_rsp_v;
   logic [DW-1:0]    r_rsp_data  [NP];

   logic [LW-1:0]    w_port_lane [NP];
   logic [LEVEL-1:0] w_win_v, w_grant, w_issue, w_fresh, w_fresh_srv, w_skid_srv;
   logic [PB-1:0]    w_win      [LEVEL];
   logic [EW-1:0]    w_wr_entry [LEVEL];
   logic [EW-1:0]    w_head     [LEVEL];
   logic [PB-1:0]    w_tag_head [LEVEL];
   logic [NP-1:0]    w_rsp_v;
   logic [DW-1:0]    w_rsp_data [NP];

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_port
         assign w_port_lane[gi] = i_req_tree_id[gi*TNB +: LW];
         assign o_rsp_data[gi*DW +: DW] = r_rsp_data[gi];
      end
      for (gi = 0; gi < LEVEL; gi++) begin : g_lane
         assign w_head[gi]     = r_rq_mem[gi][r_rq_rd[gi]];
         assign w_tag_head[gi] = r_tag_mem[gi][r_tag_rd[gi]];
         // A pop needs a free tag slot and an empty skid so a parked result
         // can never be overtaken or overwritten by a newer one.
         assign w_issue[gi] = (r_rq_cnt[gi] != '0) && !i_core_full[gi] &&
            (!w_head[gi][EW-1] ||
             ((r_tag_cnt[gi] != (TAW+1)'(TAG_DEPTH)) && !r_skid_v[gi]));
         // Returns without a tag (or during reset) are discarded.
         assign w_fresh[gi] = i_core_pop_valid[gi] && (r_tag_cnt[gi] != '0) && !i_rst;
         assign o_core_tree_id[gi*TNB +: TNB] = r_core_tree[gi];
         assign o_core_data[gi*DW +: DW]      = r_core_data[gi];
      end
   endgenerate

   assign o_core_push = r_core_push;
   assign o_core_pop  = r_core_pop;
   assign o_rsp_valid = r_rsp_v;

   // Per-lane round-robin: scan ports starting at the lane's pointer.
   always_comb begin
      for (int l = 0; l < LEVEL; l++) begin
         w_win_v[l]    = 1'b0;
         w_win[l]      = '0;
         w_wr_entry[l] = '0;
         for (int k = 0; k < NP; k++) begin
            for (int p = 0; p < NP; p++) begin
               if (!w_win_v[l] && ((int'(r_rr[l]) + k) % NP == p) &&
                   i_req_valid[p] && (w_port_lane[p] == LW'(l))) begin
                  w_win_v[l] = 1'b1;
                  w_win[l]   = PB'(p);
               end
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (w_win[l] == PB'(p))
               w_wr_entry[l] = {i_req_pop[p], PB'(p), i_req_tree_id[p*TNB +: TNB],
                                i_req_data[p*DW +: DW]};
         end
         // A full FIFO still accepts when its head leaves in the same cycle.
         w_grant[l] = w_win_v[l] && !i_rst &&
                      ((r_rq_cnt[l] != (RAW+1)'(REQ_DEPTH)) || w_issue[l]);
      end
      for (int p = 0; p < NP; p++)
         o_req_ready[p] = w_grant[w_port_lane[p]] && (w_win[w_port_lane[p]] == PB'(p));
   end

   // Return routing: parked results first, then fresh returns, lowest lane wins.
   always_comb begin
      w_rsp_v     = '0;
      w_skid_srv  = '0;
      w_fresh_srv = '0;
      for (int p = 0; p < NP; p++) begin
         w_rsp_data[p] = '0;
         for (int l = 0; l < LEVEL; l++) begin
            if (!w_rsp_v[p] && r_skid_v[l] && (r_skid_port[l] == PB'(p))) begin
               w_rsp_v[p]    = 1'b1;
               w_skid_srv[l] = 1'b1;
               w_rsp_data[p] = r_skid_data[l];
            end
         end
         for (int l = 0; l < LEVEL; l++) begin
            if (!w_rsp_v[p] && w_fresh[l] && (w_tag_head[l] == PB'(p))) begin
               w_rsp_v[p]     = 1'b1;
               w_fresh_srv[l] = 1'b1;
               w_rsp_data[p]  = i_core_pop_data[l*DW +: DW];
            end
         end
      end
   end

   // Storage without reset: contents are don't-care while pointers are reset.
   always_ff @(posedge i_clk) begin
      for (int l = 0; l < LEVEL; l++) begin
         if (w_grant[l])
            r_rq_mem[l][r_rq_wr[l]] <= w_wr_entry[l];
         if (!i_rst && w_issue[l] && w_head[l][EW-1])
            r_tag_mem[l][r_tag_wr[l]] <= w_head[l][EW-2 -: PB];
         if (w_fresh[l] && !w_fresh_srv[l]) begin
            r_skid_port[l] <= w_tag_head[l];
            r_skid_data[l] <= i_core_pop_data[l*DW +: DW];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int l = 0; l < LEVEL; l++) begin
            r_rq_rd[l]     <= '0;
            r_rq_wr[l]     <= '0;
            r_rq_cnt[l]    <= '0;
            r_tag_rd[l]    <= '0;
            r_tag_wr[l]    <= '0;
            r_tag_cnt[l]   <= '0;
            r_rr[l]        <= '0;
            r_core_tree[l] <= '0;
            r_core_data[l] <= '0;
         end
         r_skid_v    <= '0;
         r_core_push <= '0;
         r_core_pop  <= '0;
         r_rsp_v     <= '0;
         for (int p = 0; p < NP; p++)
            r_rsp_data[p] <= '0;
      end else begin
         for (int l = 0; l < LEVEL; l++) begin
            if (w_grant[l]) begin
               r_rq_wr[l] <= r_rq_wr[l] + 1'b1;
               r_rr[l]    <= (int'(w_win[l]) == NP - 1) ? '0 : w_win[l] + 1'b1;
            end
            if (w_issue[l])
               r_rq_rd[l] <= r_rq_rd[l] + 1'b1;
            r_rq_cnt[l] <= r_rq_cnt[l] + {{RAW{1'b0}}, w_grant[l]}
                                       - {{RAW{1'b0}}, w_issue[l]};
            r_core_push[l] <= w_issue[l] && !w_head[l][EW-1];
            r_core_pop[l]  <= w_issue[l] &&  w_head[l][EW-1];
            r_core_tree[l] <= w_issue[l] ? w_head[l][TNB+DW-1 -: TNB] : '0;
            r_core_data[l] <= w_issue[l] ? w_head[l][DW-1:0] : '0;
            if (w_issue[l] && w_head[l][EW-1])
               r_tag_wr[l] <= r_tag_wr[l] + 1'b1;
            if (w_fresh[l])
               r_tag_rd[l] <= r_tag_rd[l] + 1'b1;
            r_tag_cnt[l] <= r_tag_cnt[l]
                            + {{TAW{1'b0}}, (w_issue[l] && w_head[l][EW-1])}
                            - {{TAW{1'b0}}, w_fresh[l]};
            if (w_fresh[l] && !w_fresh_srv[l])
               r_skid_v[l] <= 1'b1;
            else if (w_skid_srv[l])
               r_skid_v[l] <= 1'b0;
         end
         r_rsp_v <= w_rsp_v;
         for (int p = 0; p < NP; p++)
            r_rsp_data[p] <= w_rsp_data[p];
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int l = 0; l < LEVEL; l++) begin
            if (i_core_pop_valid[l] && (r_tag_cnt[l] == '0))
               $error("io_port_mq: lane %0d returned a pop with no outstanding tag", l);
            if (w_fresh[l] && !w_fresh_srv[l] && r_skid_v[l] && !w_skid_srv[l])
               $error("io_port_mq: lane %0d skid register overflow", l);
         end
      end
   end
`endif

endmodule

// File: tb/tb_io_port_mq.sv
// tb_io_port_mq
//   Directed bench for io_port_mq (LEVEL 4, 2 ports, 8 trees, 16-bit data).
//   A negedge monitor logs every core command and client response into
//   queues; each test then compares the logged transactions against
//   hand-computed expectations through the check task.
module tb_io_port_mq;
   localparam int NP = 2;
   localparam int LV = 4;
   localparam int TN = 3;
   localparam int DW = 16;

   logic                i_clk = 1'b0;
   logic                i_rst = 1'b1;
   logic [NP-1:0]       req_valid = '0;
   logic [NP-1:0]       req_pop   = '0;
   logic [NP*TN-1:0]    req_tree  = '0;
   logic [NP*DW-1:0]    req_data  = '0;
   logic [NP-1:0]       req_ready;
   logic [NP-1:0]       rsp_valid;
   logic [NP*DW-1:0]    rsp_data;
   logic [LV-1:0]       core_push, core_pop;
   logic [LV*TN-1:0]    core_tree;
   logic [LV*DW-1:0]    core_data;
   logic [LV-1:0]       core_full = '0;
   logic [LV-1:0]       cpv = '0;
   logic [LV*DW-1:0]    cpd = '0;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct { int cyc; int lane; bit pop; int tree; logic [15:0] data; } cmd_t;
   typedef struct { int cyc; int port; logic [15:0] data; } rsp_t;
   cmd_t cmd_q[$];
   rsp_t rsp_q[$];

   io_port_mq #(.PTW(16), .MTW(0), .LEVEL(4), .TREE_NUM(8), .NUM_PORTS(2),
                .REQ_DEPTH(4), .TAG_DEPTH(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(req_valid), .i_req_pop(req_pop), .i_req_tree_id(req_tree),
      .i_req_data(req_data), .o_req_ready(req_ready),
      .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
      .o_core_push(core_push), .o_core_pop(core_pop), .o_core_tree_id(core_tree),
      .o_core_data(core_data), .i_core_full(core_full),
      .i_core_pop_valid(cpv), .i_core_pop_data(cpd)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      for (int l = 0; l < LV; l++) begin
         if (core_push[l] || core_pop[l]) begin
            cmd_q.push_back('{cyc, l, core_pop[l], int'(core_tree[l*TN +: TN]),
                              core_data[l*DW +: DW]});
            $display("cmd  cyc=%0d lane=%0d %s tree=%0d data=%h", cyc, l,
                     core_pop[l] ? "pop " : "push", core_tree[l*TN +: TN],
                     core_data[l*DW +: DW]);
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (rsp_valid[p]) begin
            rsp_q.push_back('{cyc, p, rsp_data[p*DW +: DW]});
            $display("rsp  cyc=%0d port=%0d data=%h", cyc, p, rsp_data[p*DW +: DW]);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_req(input int p, input bit v, input bit pop, input int tree,
                          input logic [15:0] d);
      req_valid[p]          = v;
      req_pop[p]            = pop;
      req_tree[p*TN +: TN]  = TN'(tree);
      req_data[p*DW +: DW]  = d;
   endtask

   // One-cycle request on an uncontended lane; returns the handshake cycle.
   task automatic send(input int p, input bit pop, input int tree, input logic [15:0] d,
                       output int hc);
      set_req(p, 1'b1, pop, tree, d);
      @(negedge i_clk);
      check("send_ready", 32'(req_ready[p]), 32'd1);
      hc = cyc;
      tick();
      set_req(p, 1'b0, 1'b0, 0, 16'h0);
   endtask

   // One-cycle core return on the lanes in m; returns the return cycle.
   task automatic ret(input logic [LV-1:0] m, input logic [LV*DW-1:0] d, output int rc);
      cpv = m;
      cpd = d;
      @(negedge i_clk);
      rc = cyc;
      tick();
      cpv = '0;
      cpd = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hc, h2, rc;
      int n0, n1;
      logic [15:0] exp_d;

      // reset state
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check("rst_core_push", 32'(core_push), 32'd0);
      check("rst_core_pop",  32'(core_pop),  32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      tick();

      // 1: single push, tree 5 -> lane 1, two cycles after the handshake
      cmd_q.delete();
      send(0, 1'b0, 5, 16'h1234, hc);
      repeat (3) tick();
      check("t1_count", 32'(cmd_q.size()), 32'd1);
      if (cmd_q.size() > 0) begin
         check("t1_lane",    32'(cmd_q[0].lane), 32'd1);
         check("t1_kind",    32'(cmd_q[0].pop),  32'd0);
         check("t1_tree",    32'(cmd_q[0].tree), 32'd5);
         check("t1_data",    32'(cmd_q[0].data), 32'h1234);
         check("t1_latency", 32'(cmd_q[0].cyc - hc), 32'd2);
      end

      // 2: both ports stream pushes to lane 2, grants alternate from port 0
      cmd_q.delete();
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 8; i++) begin
         set_req(0, 1'b1, 1'b0, 2, 16'h0A00 | 16'(n0));
         set_req(1, 1'b1, 1'b0, 2, 16'h0A10 | 16'(n1));
         @(negedge i_clk);
         check("t2_grant", 32'(req_ready), 32'(1 << (i % 2)));
         if (req_ready[0]) n0++;
         if (req_ready[1]) n1++;
         tick();
      end
      set_req(0, 1'b0, 1'b0, 0, 16'h0);
      set_req(1, 1'b0, 1'b0, 0, 16'h0);
      repeat (3) tick();
      check("t2_count", 32'(cmd_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < cmd_q.size(); i++) begin
         exp_d = ((i % 2) == 0) ? (16'h0A00 | 16'(i / 2)) : (16'h0A10 | 16'(i / 2));
         check("t2_order", {8'(cmd_q[i].lane), 8'h0, cmd_q[i].data}, {8'd2, 8'h0, exp_d});
      end

      // 3: core full on lane 0, FIFO takes 4 then back-pressures
      cmd_q.delete();
      core_full = 4'b0001;
      n0 = 0;
      for (int i = 0; i < 6; i++) begin
         set_req(0, 1'b1, 1'b0, 4, 16'h0C00 | 16'(n0));
         @(negedge i_clk);
         check("t3_ready", 32'(req_ready[0]), (i < 4) ? 32'd1 : 32'd0);
         if (req_ready[0]) n0++;
         tick();
      end
      set_req(0, 1'b0, 1'b0, 0, 16'h0);
      core_full = '0;
      rc = cyc;
      repeat (6) tick();
      check("t3_count", 32'(cmd_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
         check("t3_data", 32'(cmd_q[i].data), 32'(16'h0C00 + 16'(i)));
         check("t3_cycle", 32'(cmd_q[i].cyc - rc), 32'(i + 1));
      end

      // 4: port 1 pops tree 3, results 0x00AB then 0xFFFF (empty)
      cmd_q.delete();
      rsp_q.delete();
      send(1, 1'b1, 3, 16'h0, hc);
      repeat (2) tick();
      check("t4_cmd_count", 32'(cmd_q.size()), 32'd1);
      if (cmd_q.size() > 0)
         check("t4_cmd", {8'(cmd_q[0].lane), 7'h0, cmd_q[0].pop, 8'(cmd_q[0].tree),
                          8'(cmd_q[0].cyc - hc)}, {8'd3, 7'h0, 1'b1, 8'd3, 8'd2});
      ret(4'b1000, {16'h00AB, 48'h0}, rc);
      tick();
      check("t4_rsp_count", 32'(rsp_q.size()), 32'd1);
      if (rsp_q.size() > 0)
         check("t4_rsp", {8'(rsp_q[0].cyc - rc), 8'(rsp_q[0].port), rsp_q[0].data},
                         {8'd1, 8'd1, 16'h00AB});
      send(1, 1'b1, 7, 16'h0, hc);
      repeat (2) tick();
      ret(4'b1000, {16'hFFFF, 48'h0}, rc);
      tick();
      check("t4_empty_count", 32'(rsp_q.size()), 32'd2);
      if (rsp_q.size() > 1)
         check("t4_empty", {8'(rsp_q[1].cyc - rc), 8'(rsp_q[1].port), rsp_q[1].data},
                           {8'd1, 8'd1, 16'hFFFF});

      // 5: lanes 0 and 3 return to port 0 together; lane 3 parks one cycle
      cmd_q.delete();
      rsp_q.delete();
      send(0, 1'b1, 0, 16'h0, hc);
      send(0, 1'b1, 3, 16'h0, h2);
      repeat (2) tick();
      cpv = 4'b1001;
      cpd = {16'h0333, 16'h0, 16'h0, 16'h0111};
      set_req(1, 1'b1, 1'b1, 3, 16'h0);
      @(negedge i_clk);
      rc = cyc;
      check("t5_ready", 32'(req_ready[1]), 32'd1);
      tick();
      cpv = '0;
      cpd = '0;
      set_req(1, 1'b0, 1'b0, 0, 16'h0);
      repeat (4) tick();
      check("t5_rsp_count", 32'(rsp_q.size()), 32'd2);
      if (rsp_q.size() > 1) begin
         check("t5_rsp_first",  {8'(rsp_q[0].cyc - rc), 8'(rsp_q[0].port), rsp_q[0].data},
                                {8'd1, 8'd0, 16'h0111});
         check("t5_rsp_second", {8'(rsp_q[1].cyc - rc), 8'(rsp_q[1].port), rsp_q[1].data},
                                {8'd2, 8'd0, 16'h0333});
      end
      check("t5_cmd_count", 32'(cmd_q.size()), 32'd3);
      if (cmd_q.size() > 2)
         check("t5_stall", {8'(cmd_q[2].lane), 7'h0, cmd_q[2].pop, 16'(cmd_q[2].cyc - rc)},
                           {8'd3, 7'h0, 1'b1, 16'd3});
      ret(4'b1000, {16'h0444, 48'h0}, rc);
      tick();
      check("t5_rsp3_count", 32'(rsp_q.size()), 32'd3);
      if (rsp_q.size() > 2)
         check("t5_rsp3", {8'(rsp_q[2].port), 8'h0, rsp_q[2].data}, {8'd1, 8'h0, 16'h0444});

      // 6: reset with 3 requests queued and 2 pops outstanding
      send(0, 1'b1, 1, 16'h0, hc);
      send(0, 1'b1, 2, 16'h0, hc);
      repeat (2) tick();
      core_full = 4'b1111;
      send(1, 1'b0, 0, 16'h0600, hc);
      send(1, 1'b0, 1, 16'h0601, hc);
      send(1, 1'b0, 2, 16'h0602, hc);
      cmd_q.delete();
      rsp_q.delete();
      i_rst = 1'b1;
      cpv = 4'b0110;
      cpd = {16'h0, 16'h0666, 16'h0666, 16'h0};
      tick();
      i_rst = 1'b0;
      cpv = '0;
      cpd = '0;
      core_full = '0;
      @(negedge i_clk);
      check("t6_core_push", 32'(core_push), 32'd0);
      check("t6_core_pop",  32'(core_pop),  32'd0);
      check("t6_core_tree", 32'(core_tree), 32'd0);
      check("t6_core_data", 32'(|core_data), 32'd0);
      check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t6_rsp_data",  32'(rsp_data),  32'd0);
      tick();
      repeat (5) tick();
      check("t6_no_cmd", 32'(cmd_q.size()), 32'd0);
      check("t6_no_rsp", 32'(rsp_q.size()), 32'd0);
      send(1, 1'b1, 1, 16'h0, hc);
      repeat (2) tick();
      ret(4'b0010, {16'h0, 16'h0, 16'h0777, 16'h0}, rc);
      tick();
      check("t6_post_count", 32'(rsp_q.size()), 32'd1);
      if (rsp_q.size() > 0)
         check("t6_post_rsp", {8'(rsp_q[0].cyc - rc), 8'(rsp_q[0].port), rsp_q[0].data},
                              {8'd1, 8'd1, 16'h0777});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
